// File: rtl/irq_gateway.sv
// irq_gateway: synchronises raw interrupt sources, qualifies them as edge or level,
// queues edge events per line and holds a clean request until the controller completes it.
module irq_gateway #(
  parameter int N_IRQ  = 16,
  parameter int QDEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] src_i,
  input  logic [N_IRQ-1:0] mode_i,
  input  logic [N_IRQ-1:0] irq_ret_i,
  input  logic [N_IRQ-1:0] lost_clr_i,
  output logic [N_IRQ-1:0] irq_req_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] lost_o
);
  localparam int            CW     = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] C_QMAX = CW'(QDEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;
  logic [N_IRQ-1:0] r_sd;
  logic [N_IRQ-1:0] r_mode_q;
  logic [N_IRQ-1:0] w_rise;

  // Two-flop synchroniser, one-cycle delay for edge detection, and mode register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync1  <= {N_IRQ{1'b0}};
      r_sync2  <= {N_IRQ{1'b0}};
      r_sd     <= {N_IRQ{1'b0}};
      r_mode_q <= {N_IRQ{1'b0}};
    end else begin
      r_sync1  <= src_i;
      r_sync2  <= r_sync1;
      r_sd     <= r_sync2;
      r_mode_q <= mode_i;
    end
  end

  assign w_rise = r_sync2 & ~r_sd;

  for (genvar k = 0; k < N_IRQ; k++) begin : g_line
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_lost;
    logic          w_lost_nx;
    logic          r_req;
    logic          r_pend;
    logic          w_edge;
    logic          w_ret;
    logic          w_flip;
    logic          w_inc;
    logic          w_dec;
    logic          w_ovf;

    assign w_edge = r_mode_q[k];
    // Completion only counts while the request is actually being presented.
    assign w_ret  = irq_ret_i[k] & (r_state == ST_PEND);
    assign w_flip = mode_i[k] ^ r_mode_q[k];
    assign w_inc  = w_edge & w_rise[k] & ~w_ret;
    assign w_dec  = w_edge & w_ret & ~w_rise[k];
    assign w_ovf  = w_inc & (r_cnt == C_QMAX);

    // Queue counter, lost flag and per-line next state.
    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_lost_nx  = r_lost;
      if (w_ovf) begin
        w_lost_nx = 1'b1;
      end else if (lost_clr_i[k]) begin
        w_lost_nx = 1'b0;
      end else begin
        w_lost_nx = r_lost;
      end
      if (w_flip) begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = C_ZERO;
      end else begin
        if (!w_edge) begin
          w_cnt_nx = C_ZERO;
        end else if (w_inc && !w_ovf) begin
          w_cnt_nx = r_cnt + C_ONE;
        end else if (w_dec && (r_cnt != C_ZERO)) begin
          w_cnt_nx = r_cnt - C_ONE;
        end else begin
          w_cnt_nx = r_cnt;
        end
        case (r_state)
          ST_IDLE: begin
            if (w_edge ? w_rise[k] : r_sync2[k]) w_state_nx = ST_PEND;
            else                                 w_state_nx = ST_IDLE;
          end
          ST_PEND: begin
            if (irq_ret_i[k]) w_state_nx = ST_HOLD;
            else              w_state_nx = ST_PEND;
          end
          // Re-arm on the updated count so an edge landing in the gap is not stranded.
          ST_HOLD: begin
            if (w_edge ? (w_cnt_nx != C_ZERO) : r_sync2[k]) w_state_nx = ST_PEND;
            else                                            w_state_nx = ST_IDLE;
          end
          default: w_state_nx = ST_IDLE;
        endcase
      end
    end

    // Line state, counter and registered outputs.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state <= ST_IDLE;
        r_cnt   <= C_ZERO;
        r_lost  <= 1'b0;
        r_req   <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_lost  <= w_lost_nx;
        r_req   <= (w_state_nx == ST_PEND);
        r_pend  <= (w_state_nx != ST_IDLE);
      end
    end

    assign irq_req_o[k] = r_req;
    assign pending_o[k] = r_pend;
    assign lost_o[k]    = r_lost;
  end

endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_irq_gateway;
  localparam int N  = 16;
  localparam int QD = 3;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] src_i = '0;
  logic [N-1:0] mode_i = '1;
  logic [N-1:0] irq_ret_i = '0;
  logic [N-1:0] lost_clr_i = '0;
  logic [N-1:0] irq_req_o;
  logic [N-1:0] pending_o;
  logic [N-1:0] lost_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  irq_gateway #(.N_IRQ(N), .QDEPTH(QD)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .src_i      (src_i),
    .mode_i     (mode_i),
    .irq_ret_i  (irq_ret_i),
    .lost_clr_i (lost_clr_i),
    .irq_req_o  (irq_req_o),
    .pending_o  (pending_o),
    .lost_o     (lost_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: src history, queued event count, service phase
  // (0 quiet, 1 request shown, 2 deassertion gap) and sticky lost flag.
  bit [2:0] m_hist [N];
  bit       m_mq   [N];
  bit       m_lost [N];
  int       m_q    [N];
  int       m_ph   [N];

  always @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      bit s_now;
      bit rise;
      bit is_edge;
      bit served;
      bit nl;
      int nq;
      int nph;
      s_now   = m_hist[k][1];
      rise    = m_hist[k][1] & ~m_hist[k][2];
      is_edge = m_mq[k];
      served  = irq_ret_i[k] && (m_ph[k] == 1);
      nq = is_edge ? (m_q[k] + int'(rise) - int'(served)) : 0;
      if (nq > QD) nq = QD;
      nl = m_lost[k];
      if (lost_clr_i[k]) nl = 1'b0;
      if (is_edge && rise && !served && (m_q[k] == QD)) nl = 1'b1;
      case (m_ph[k])
        0:       nph = (is_edge ? rise : s_now) ? 1 : 0;
        1:       nph = irq_ret_i[k] ? 2 : 1;
        default: nph = (is_edge ? (nq > 0) : s_now) ? 1 : 0;
      endcase
      if (mode_i[k] != m_mq[k]) begin
        nph = 0;
        nq  = 0;
      end
      if (!rst_ni) begin
        m_hist[k] <= 3'b000;
        m_mq[k]   <= 1'b0;
        m_lost[k] <= 1'b0;
        m_q[k]    <= 0;
        m_ph[k]   <= 0;
      end else begin
        m_hist[k] <= {m_hist[k][1:0], src_i[k]};
        m_mq[k]   <= mode_i[k];
        m_lost[k] <= nl;
        m_q[k]    <= nq;
        m_ph[k]   <= nph;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      logic [N-1:0] e_req;
      logic [N-1:0] e_pend;
      logic [N-1:0] e_lost;
      for (int k = 0; k < N; k++) begin
        e_req[k]  = (m_ph[k] == 1);
        e_pend[k] = (m_ph[k] != 0);
        e_lost[k] = m_lost[k];
      end
      checks++;
      if ((irq_req_o !== e_req) || (pending_o !== e_pend) || (lost_o !== e_lost)) begin
        errors++;
        $display("FAIL model t=%0t req %h want %h pend %h want %h lost %h want %h",
                 $time, irq_req_o, e_req, pending_o, e_pend, lost_o, e_lost);
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic pulse_src(input int k, input int hi, input int lo);
    src_i[k] = 1'b1;
    repeat (hi) tick();
    src_i[k] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_ret(input int k, input logic back);
    irq_ret_i[k] = 1'b1;
    tick();
    irq_ret_i = '0;
    chk("gap_req", N'(irq_req_o[k]), N'(1'b0));
    chk("gap_pend", N'(pending_o[k]), N'(1'b1));
    tick();
    chk("after_req", N'(irq_req_o[k]), N'(back));
    chk("after_pend", N'(pending_o[k]), N'(back));
  endtask

  initial begin
    logic [N-1:0] one;
    one = 16'h0001;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_req", irq_req_o, 16'h0000);
    chk("rst_pend", pending_o, 16'h0000);
    chk("rst_lost", lost_o, 16'h0000);
    rst_ni = 1'b1;
    repeat (2) tick();

    // Single edge event, latency and one-cycle gap.
    src_i[3] = 1'b1;
    tick(); chk("lat1", N'(irq_req_o[3]), N'(1'b0));
    tick(); chk("lat2", N'(irq_req_o[3]), N'(1'b0));
    tick(); chk("lat3", N'(irq_req_o[3]), N'(1'b1));
    tick(); src_i[3] = 1'b0;
    repeat (2) tick();
    chk("held", N'(irq_req_o[3]), N'(1'b1));
    do_ret(3, 1'b0);
    tick(); chk("idle3", N'(pending_o[3]), N'(1'b0));

    // Three queued edges, three services.
    repeat (3) pulse_src(5, 2, 2);
    repeat (2) tick();
    chk("q3_req", N'(irq_req_o[5]), N'(1'b1));
    do_ret(5, 1'b1); tick();
    do_ret(5, 1'b1); tick();
    do_ret(5, 1'b0);

    // Overflow, clear, and overflow coincident with clear.
    repeat (4) pulse_src(5, 2, 2);
    chk("ovf_lost", N'(lost_o[5]), N'(1'b1));
    lost_clr_i[5] = 1'b1; tick(); lost_clr_i[5] = 1'b0;
    chk("clr_lost", N'(lost_o[5]), N'(1'b0));
    src_i[5] = 1'b1; tick(); tick();
    lost_clr_i[5] = 1'b1; tick(); lost_clr_i[5] = 1'b0;
    chk("set_wins", N'(lost_o[5]), N'(1'b1));
    src_i[5] = 1'b0; repeat (2) tick();
    lost_clr_i[5] = 1'b1; tick(); lost_clr_i[5] = 1'b0;
    do_ret(5, 1'b1); tick();
    do_ret(5, 1'b1); tick();
    do_ret(5, 1'b0);

    // Level mode on line 0.
    mode_i[0] = 1'b0; tick();
    src_i[0] = 1'b1; repeat (4) tick();
    chk("lvl_req", N'(irq_req_o[0]), N'(1'b1));
    do_ret(0, 1'b1);
    src_i[0] = 1'b0; repeat (4) tick();
    chk("lvl_keep", N'(irq_req_o[0]), N'(1'b1));
    do_ret(0, 1'b0);

    // Rise coincident with ret at cnt 1; ret to an idle line.
    pulse_src(7, 2, 2); tick();
    chk("c_req", N'(irq_req_o[7]), N'(1'b1));
    src_i[7] = 1'b1; tick(); tick();
    irq_ret_i[7] = 1'b1; tick(); irq_ret_i = '0;
    chk("c_gap", N'(irq_req_o[7]), N'(1'b0));
    tick(); chk("c_back", N'(irq_req_o[7]), N'(1'b1));
    src_i[7] = 1'b0; repeat (2) tick();
    do_ret(7, 1'b0);
    chk("c_lost", N'(lost_o[7]), N'(1'b0));
    irq_ret_i[9] = 1'b1; tick(); irq_ret_i = '0;
    chk("idle_ret", N'(pending_o[9]), N'(1'b0));

    // Mode flip on a pending line.
    pulse_src(10, 2, 2);
    chk("f_req", N'(irq_req_o[10]), N'(1'b1));
    mode_i[10] = 1'b0; tick();
    chk("f_drop", N'(irq_req_o[10]), N'(1'b0));
    mode_i[10] = 1'b1; repeat (4) tick();
    chk("f_cnt0", N'(irq_req_o[10]), N'(1'b0));

    // Reset mid-service with source held high.
    src_i[12] = 1'b1; repeat (4) tick();
    chk("r_req", N'(irq_req_o[12]), N'(1'b1));
    rst_ni = 1'b0; tick();
    chk("r_clr", irq_req_o | pending_o | lost_o, 16'h0000);
    tick(); rst_ni = 1'b1;
    tick(); chk("r_lat1", N'(irq_req_o[12]), N'(1'b0));
    tick(); chk("r_lat2", N'(irq_req_o[12]), N'(1'b0));
    tick(); chk("r_lat3", N'(irq_req_o[12]), N'(1'b1));
    src_i[12] = 1'b0;

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      src_i = src_i ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 99) == 0) mode_i[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) < 4) irq_ret_i = one << $urandom_range(0, N - 1);
      else if ($urandom_range(0, 19) == 0) irq_ret_i = N'($urandom);
      else irq_ret_i = '0;
      lost_clr_i = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      rst_ni = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_ni = 1'b1;
    irq_ret_i = '0;
    lost_clr_i = '0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
